// File: rtl/tank_pkg.sv
// rtl/tank_pkg.sv - shared types, key codes and fixed-point helpers for tank_ctrl_param
package tank_pkg;

  typedef enum logic [1:0] {
    ALIVE   = 2'd0,
    DYING   = 2'd1,
    RESPAWN = 2'd2
  } tank_state_e;

  localparam logic [7:0] KEY_FWD  = 8'h52;
  localparam logic [7:0] KEY_BACK = 8'h51;
  localparam logic [7:0] KEY_CCW  = 8'h50;
  localparam logic [7:0] KEY_CW   = 8'h4F;
  localparam logic [7:0] KEY_FIRE = 8'h2C;

  // Integer pixel width of a position; trig inputs are Q1.7 sign-magnitude.
  localparam int POS_W      = 10;
  localparam int TRIG_MAG_W = 7;

  // Scale a sign-magnitude Q1.7 value by full_scale; 0x80 collapses to 0.
  function automatic int sm_scale(input logic [7:0] sm, input int full_scale);
    int mag;
    mag = (full_scale * int'({25'd0, sm[6:0]})) >>> TRIG_MAG_W;
    return sm[7] ? -mag : mag;
  endfunction

endpackage

// File: rtl/tank_step_calc.sv
// rtl/tank_step_calc.sv - combinational fixed-point step and arena clamp producing the proposed move
module tank_step_calc
  import tank_pkg::*;
#(
  parameter int FRAC  = 4,
  parameter int SPEED = 32,
  parameter int X_MIN = 0,
  parameter int X_MAX = 639,
  parameter int Y_MIN = 0,
  parameter int Y_MAX = 479,
  parameter int SIZE  = 10
) (
  input  logic [POS_W+FRAC-1:0] pos_x,
  input  logic [POS_W+FRAC-1:0] pos_y,
  input  logic [7:0]            sin,
  input  logic [7:0]            cos,
  input  logic                  move_fwd,
  input  logic                  move_back,
  output logic [POS_W+FRAC-1:0] prop_x,
  output logic [POS_W+FRAC-1:0] prop_y
);

  localparam int QW = POS_W + FRAC;

  // A clamped axis lands exactly on the limit pixel with its fraction cleared.
  function automatic logic [QW-1:0] clamp_axis(input int q, input int lo, input int hi);
    int ip;
    ip = q >>> FRAC;
    if (ip < lo) return {POS_W'(lo), {FRAC{1'b0}}};
    if (ip > hi) return {POS_W'(hi), {FRAC{1'b0}}};
    return q[QW-1:0];
  endfunction

  int dx;
  int dy;

  always_comb begin
    dx     = sm_scale(cos, SPEED);
    dy     = -sm_scale(sin, SPEED);  // screen Y grows downward
    prop_x = pos_x;
    prop_y = pos_y;
    if (move_back) begin
      dx = -dx;
      dy = -dy;
    end
    if (move_fwd || move_back) begin
      prop_x = clamp_axis(int'(pos_x) + dx, X_MIN + SIZE, X_MAX - SIZE);
      prop_y = clamp_axis(int'(pos_y) + dy, Y_MIN + SIZE, Y_MAX - SIZE);
    end
  end

endmodule

// File: rtl/tank_ctrl_param.sv
// rtl/tank_ctrl_param.sv - per-player tank movement, firing and life-cycle controller
module tank_ctrl_param
  import tank_pkg::*;
#(
  parameter int         KEY_SLOTS     = 4,
  parameter logic [7:0] K_FWD         = KEY_FWD,
  parameter logic [7:0] K_BACK        = KEY_BACK,
  parameter logic [7:0] K_CCW         = KEY_CCW,
  parameter logic [7:0] K_CW          = KEY_CW,
  parameter logic [7:0] K_FIRE        = KEY_FIRE,
  parameter int         N_ANGLES      = 48,
  parameter int         ANG_W         = 6,
  parameter int         FRAC          = 4,
  parameter int         SPEED         = 32,
  parameter int         X_SPAWN       = 300,
  parameter int         Y_SPAWN       = 250,
  parameter int         X_MIN         = 0,
  parameter int         X_MAX         = 639,
  parameter int         Y_MIN         = 0,
  parameter int         Y_MAX         = 479,
  parameter int         SIZE          = 10,
  parameter int         FIRE_COOLDOWN = 30,
  parameter int         DEATH_FRAMES  = 60
) (
  input  logic                   frame_clk,
  input  logic                   Reset_n,
  input  logic [8*KEY_SLOTS-1:0] keycode,
  input  logic [7:0]             sin,
  input  logic [7:0]             cos,
  input  logic                   wall_hit,
  input  logic                   hit,
  output logic [9:0]             TankX,
  output logic [9:0]             TankY,
  output logic [9:0]             TankS,
  output logic [ANG_W-1:0]       Angle,
  output logic [9:0]             PropX,
  output logic [9:0]             PropY,
  output logic                   Fire,
  output logic                   Alive
);

  localparam int QW   = POS_W + FRAC;
  localparam int CD_W = $clog2(FIRE_COOLDOWN + 1);
  localparam int DC_W = $clog2(DEATH_FRAMES + 1);
  localparam logic [QW-1:0] X_SPAWN_Q = {POS_W'(X_SPAWN), {FRAC{1'b0}}};
  localparam logic [QW-1:0] Y_SPAWN_Q = {POS_W'(Y_SPAWN), {FRAC{1'b0}}};

  tank_state_e     state, state_nxt;
  logic [QW-1:0]   pos_x, pos_y, pos_x_nxt, pos_y_nxt, prop_x_q, prop_y_q;
  logic [ANG_W-1:0] angle, angle_nxt;
  logic [CD_W-1:0] cooldown, cooldown_nxt;
  logic [DC_W-1:0] death_cnt, death_nxt;
  logic            fire_q, fire_nxt;
  logic            key_fwd, key_back, key_ccw, key_cw, key_fire;
  logic            act, move_fwd, move_back, rot_ccw, rot_cw;

  always_comb begin
    key_fwd  = 1'b0;
    key_back = 1'b0;
    key_ccw  = 1'b0;
    key_cw   = 1'b0;
    key_fire = 1'b0;
    for (int i = 0; i < KEY_SLOTS; i++) begin
      if (keycode[8*i +: 8] == K_FWD)  key_fwd  = 1'b1;
      if (keycode[8*i +: 8] == K_BACK) key_back = 1'b1;
      if (keycode[8*i +: 8] == K_CCW)  key_ccw  = 1'b1;
      if (keycode[8*i +: 8] == K_CW)   key_cw   = 1'b1;
      if (keycode[8*i +: 8] == K_FIRE) key_fire = 1'b1;
    end
  end

  // A hit in the same frame pre-empts every action, so gate on it here.
  assign act       = (state == ALIVE) && !hit;
  assign move_fwd  = act && key_fwd;
  assign move_back = act && !key_fwd && key_back;
  assign rot_ccw   = act && !key_fwd && !key_back && key_ccw;
  assign rot_cw    = act && !key_fwd && !key_back && !key_ccw && key_cw;

  tank_step_calc #(
    .FRAC(FRAC), .SPEED(SPEED), .X_MIN(X_MIN), .X_MAX(X_MAX),
    .Y_MIN(Y_MIN), .Y_MAX(Y_MAX), .SIZE(SIZE)
  ) u_step (
    .pos_x(pos_x), .pos_y(pos_y), .sin(sin), .cos(cos),
    .move_fwd(move_fwd), .move_back(move_back),
    .prop_x(prop_x_q), .prop_y(prop_y_q)
  );

  always_comb begin
    state_nxt    = state;
    pos_x_nxt    = pos_x;
    pos_y_nxt    = pos_y;
    angle_nxt    = angle;
    death_nxt    = death_cnt;
    fire_nxt     = 1'b0;
    cooldown_nxt = (cooldown != '0) ? cooldown - CD_W'(1) : cooldown;
    case (state)
      ALIVE: begin
        if (hit) begin
          state_nxt = DYING;
          death_nxt = DC_W'(DEATH_FRAMES - 1);
        end else begin
          if ((move_fwd || move_back) && !wall_hit) begin
            pos_x_nxt = prop_x_q;
            pos_y_nxt = prop_y_q;
          end
          if (rot_ccw) angle_nxt = (angle == ANG_W'(N_ANGLES - 1)) ? '0 : angle + ANG_W'(1);
          if (rot_cw)  angle_nxt = (angle == '0) ? ANG_W'(N_ANGLES - 1) : angle - ANG_W'(1);
          if (key_fire && cooldown == '0) begin
            fire_nxt     = 1'b1;
            cooldown_nxt = CD_W'(FIRE_COOLDOWN);
          end
        end
      end
      DYING: begin
        if (death_cnt == '0) state_nxt = RESPAWN;
        else                 death_nxt = death_cnt - DC_W'(1);
      end
      RESPAWN: begin
        state_nxt    = ALIVE;
        pos_x_nxt    = X_SPAWN_Q;
        pos_y_nxt    = Y_SPAWN_Q;
        angle_nxt    = '0;
        cooldown_nxt = '0;
      end
      default: state_nxt = ALIVE;
    endcase
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ALIVE;
      pos_x     <= X_SPAWN_Q;
      pos_y     <= Y_SPAWN_Q;
      angle     <= '0;
      cooldown  <= '0;
      death_cnt <= '0;
      fire_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      pos_x     <= pos_x_nxt;
      pos_y     <= pos_y_nxt;
      angle     <= angle_nxt;
      cooldown  <= cooldown_nxt;
      death_cnt <= death_nxt;
      fire_q    <= fire_nxt;
    end
  end

  assign TankX = pos_x[QW-1:FRAC];
  assign TankY = pos_y[QW-1:FRAC];
  assign TankS = POS_W'(SIZE);
  assign PropX = prop_x_q[QW-1:FRAC];
  assign PropY = prop_y_q[QW-1:FRAC];
  assign Angle = angle;
  assign Fire  = fire_q;
  assign Alive = (state == ALIVE);

endmodule

// File: tb/tb_tank_ctrl_param.sv
// tb/tb_tank_ctrl_param.sv - self-checking bench for tank_ctrl_param
module tb_tank_ctrl_param;

  logic        frame_clk = 1'b0;
  logic        Reset_n;
  logic [31:0] keycode;
  logic [7:0]  sin, cos;
  logic        wall_hit, hit;
  logic [9:0]  TankX, TankY, TankS, PropX, PropY;
  logic [5:0]  Angle;
  logic        Fire, Alive;

  tank_ctrl_param dut (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .keycode(keycode),
    .sin(sin), .cos(cos), .wall_hit(wall_hit), .hit(hit),
    .TankX(TankX), .TankY(TankY), .TankS(TankS), .Angle(Angle),
    .PropX(PropX), .PropY(PropY), .Fire(Fire), .Alive(Alive)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    int x, y, ang;
    logic fire, alive;
    string tag;
  } exp_t;

  typedef struct {
    logic [31:0] kc;
    logic [7:0]  s, c;
    logic        wall, hit;
    int          px, py, x, y, ang;
  } vec_t;

  exp_t sb[$];
  vec_t vt[12];
  int checks = 0;
  int errors = 0;
  int xq;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int x, input int y, input int ang,
                              input logic fire, input logic alive, input string tag);
    exp_t e;
    e.x = x; e.y = y; e.ang = ang; e.fire = fire; e.alive = alive; e.tag = tag;
    return e;
  endfunction

  // Expected result is queued when stimulus is applied, then popped after the edge.
  task automatic frame(input exp_t e);
    exp_t g;
    sb.push_back(e);
    @(posedge frame_clk);
    #1;
    g = sb.pop_front();
    check({g.tag, ".x"},     int'(TankX), g.x);
    check({g.tag, ".y"},     int'(TankY), g.y);
    check({g.tag, ".ang"},   int'(Angle), g.ang);
    check({g.tag, ".fire"},  int'(Fire),  int'(g.fire));
    check({g.tag, ".alive"}, int'(Alive), int'(g.alive));
  endtask

  initial begin
    // Q4 arithmetic: full-scale step is (32*127)>>7 = 31 sixteenths of a pixel.
    vt[0]  = '{32'h0052_0000, 8'h00, 8'h7F, 0, 0, 301, 250, 301, 250, 0};
    vt[1]  = '{32'h0052_0000, 8'h00, 8'h7F, 0, 0, 303, 250, 303, 250, 0};
    vt[2]  = '{32'h0000_004F, 8'h00, 8'h7F, 0, 0, 303, 250, 303, 250, 47};
    vt[3]  = '{32'h0000_0050, 8'h00, 8'h7F, 0, 0, 303, 250, 303, 250, 0};
    vt[4]  = '{32'h5000_0000, 8'h00, 8'h7F, 0, 0, 303, 250, 303, 250, 1};
    vt[5]  = '{32'h004F_0052, 8'h00, 8'h7F, 0, 0, 305, 250, 305, 250, 1};
    vt[6]  = '{32'h0000_0052, 8'h00, 8'h7F, 1, 0, 307, 250, 305, 250, 1};
    vt[7]  = '{32'h0000_5100, 8'h00, 8'h7F, 0, 0, 303, 250, 303, 250, 1};
    vt[8]  = '{32'h0000_0052, 8'h7F, 8'h00, 0, 0, 303, 248, 303, 248, 1};
    vt[9]  = '{32'h0000_0052, 8'hFF, 8'h80, 0, 0, 303, 250, 303, 250, 1};
    vt[10] = '{32'h0000_0051, 8'h00, 8'hC0, 0, 0, 304, 250, 304, 250, 1};
    vt[11] = '{32'h0000_0000, 8'h00, 8'h7F, 0, 0, 304, 250, 304, 250, 1};

    Reset_n = 1'b0; keycode = '0; sin = 8'h00; cos = 8'h7F; wall_hit = 1'b0; hit = 1'b0;
    repeat (2) @(posedge frame_clk);
    #1;
    Reset_n = 1'b1;
    check("rst.x", int'(TankX), 300);
    check("rst.y", int'(TankY), 250);
    check("rst.ang", int'(Angle), 0);
    check("rst.alive", int'(Alive), 1);
    check("rst.fire", int'(Fire), 0);
    check("rst.size", int'(TankS), 10);
    check("rst.propx", int'(PropX), 300);

    for (int i = 0; i < 12; i++) begin
      keycode = vt[i].kc; sin = vt[i].s; cos = vt[i].c;
      wall_hit = vt[i].wall; hit = vt[i].hit;
      #1;
      check($sformatf("v%0d.propx", i), int'(PropX), vt[i].px);
      check($sformatf("v%0d.propy", i), int'(PropY), vt[i].py);
      frame(mk(vt[i].x, vt[i].y, vt[i].ang, 1'b0, 1'b1, $sformatf("v%0d", i)));
    end
    wall_hit = 1'b0;

    keycode = 32'h0000_002C;
    for (int i = 0; i <= 62; i++)
      frame(mk(304, 250, 1, (i % 31) == 0, 1'b1, $sformatf("fire%0d", i)));

    keycode = 32'h0000_0052; sin = 8'h00; cos = 8'h7F;
    xq = 304 * 16 + 14;
    for (int i = 0; i < 180; i++) begin
      if (((xq + 31) >> 4) > 629) xq = 629 * 16;
      else                        xq = xq + 31;
      frame(mk(xq >> 4, 250, 1, 1'b0, 1'b1, $sformatf("clamp%0d", i)));
    end
    #1;
    check("clamp.propx", int'(PropX), 629);

    hit = 1'b1;
    frame(mk(629, 250, 1, 1'b0, 1'b0, "hit"));
    hit = 1'b0;
    keycode = 32'h2C4F_0052;
    for (int i = 1; i < 60; i++)
      frame(mk(629, 250, 1, 1'b0, 1'b0, $sformatf("dying%0d", i)));
    keycode = '0;
    frame(mk(629, 250, 1, 1'b0, 1'b0, "respawn"));
    frame(mk(300, 250, 0, 1'b0, 1'b1, "alive_again"));
    keycode = 32'h0000_002C;
    frame(mk(300, 250, 0, 1'b1, 1'b1, "fire_after_respawn"));

    keycode = 32'h0000_0050;
    frame(mk(300, 250, 1, 1'b0, 1'b1, "pre_hit_ccw"));
    keycode = '0; hit = 1'b1;
    frame(mk(300, 250, 1, 1'b0, 1'b0, "hit2"));
    hit = 1'b0;
    for (int i = 0; i < 10; i++)
      frame(mk(300, 250, 1, 1'b0, 1'b0, $sformatf("dying2_%0d", i)));
    #2;
    Reset_n = 1'b0;
    #1;
    check("midrst.alive", int'(Alive), 1);
    check("midrst.x", int'(TankX), 300);
    check("midrst.y", int'(TankY), 250);
    check("midrst.ang", int'(Angle), 0);
    check("midrst.fire", int'(Fire), 0);
    Reset_n = 1'b1;
    frame(mk(300, 250, 0, 1'b0, 1'b1, "post_rst"));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
